// File: rtl/umai_tx_chn_sched.sv
// Whole-packet arbiter between the UMAI master and slave flit paths that
// stripes each granted packet round-robin across a window of AIB TX channels.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | no grant; ptr tracks c_first_chn_id; arbitration cycle
// ST_GNT_MST | master path owns the channels until its last flit
// ST_GNT_SLV | slave path owns the channels until its last flit
module umai_tx_chn_sched #(
  parameter int NumChannels = 6
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_en,
  input  logic [2:0]                   c_first_chn_id,
  input  logic [2:0]                   c_last_chn_id,
  input  logic                         i_mst_valid,
  output logic                         o_mst_ready,
  input  logic [71:0]                  i_mst_data,
  input  logic                         i_mst_last,
  input  logic                         i_slv_valid,
  output logic                         o_slv_ready,
  input  logic [71:0]                  i_slv_data,
  input  logic                         i_slv_last,
  output logic [NumChannels-1:0]       o_tx_valid,
  input  logic [NumChannels-1:0]       i_tx_ready,
  output logic [NumChannels-1:0][71:0] o_tx_data,
  output logic                         o_busy,
  output logic                         o_cfg_err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GNT_MST = 2'd1,
    ST_GNT_SLV = 2'd2
  } state_t;

  localparam logic       SRC_MST = 1'b0;
  localparam logic       SRC_SLV = 1'b1;
  localparam logic [3:0] NCH     = 4'(NumChannels);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_rr_last;
  logic [2:0]  r_ptr;
  logic        r_out_vld;
  logic [71:0] r_out_data;
  logic [2:0]  r_out_chn;

  logic        w_cfg_err;
  logic        w_chn_rdy;
  logic        w_drain;
  logic        w_mst_acc;
  logic        w_slv_acc;
  logic        w_acc;
  logic [71:0] w_acc_data;
  logic [2:0]  w_ptr_nxt;

  assign w_cfg_err = (c_first_chn_id > c_last_chn_id) || ({1'b0, c_last_chn_id} >= NCH);
  // Held low in reset so every output reads 0 regardless of config.
  assign o_cfg_err = !i_rst && w_cfg_err;

  always_comb begin
    w_chn_rdy = 1'b0;
    for (int k = 0; k < NumChannels; k++) begin
      if (r_out_chn == k[2:0]) w_chn_rdy = i_tx_ready[k];
    end
  end

  always_comb begin
    for (int k = 0; k < NumChannels; k++) begin
      o_tx_valid[k] = r_out_vld && (r_out_chn == k[2:0]);
      o_tx_data[k]  = r_out_data;
    end
  end

  assign w_drain    = r_out_vld && w_chn_rdy;
  assign w_mst_acc  = i_mst_valid && o_mst_ready;
  assign w_slv_acc  = i_slv_valid && o_slv_ready;
  assign w_acc      = w_mst_acc || w_slv_acc;
  assign w_acc_data = w_mst_acc ? i_mst_data : i_slv_data;
  assign w_ptr_nxt  = (r_ptr == c_last_chn_id) ? c_first_chn_id : r_ptr + 3'd1;
  assign o_busy     = (r_state != ST_IDLE) || r_out_vld;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_en && !w_cfg_err) begin
          if (i_mst_valid && (!i_slv_valid || (r_rr_last == SRC_SLV))) w_state_nxt = ST_GNT_MST;
          else if (i_slv_valid)                                         w_state_nxt = ST_GNT_SLV;
        end
      end
      ST_GNT_MST: if (w_mst_acc && i_mst_last) w_state_nxt = ST_IDLE;
      ST_GNT_SLV: if (w_slv_acc && i_slv_last) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_mst_ready = (r_state == ST_GNT_MST) && (!r_out_vld || w_drain);
    o_slv_ready = (r_state == ST_GNT_SLV) && (!r_out_vld || w_drain);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rr_last  <= SRC_SLV;
      r_ptr      <= 3'd0;
      r_out_vld  <= 1'b0;
      r_out_data <= 72'd0;
      r_out_chn  <= 3'd0;
    end else begin
      if (r_state == ST_IDLE) begin
        r_ptr <= c_first_chn_id;
        if (w_state_nxt == ST_GNT_MST)      r_rr_last <= SRC_MST;
        else if (w_state_nxt == ST_GNT_SLV) r_rr_last <= SRC_SLV;
      end else if (w_acc) begin
        r_ptr <= w_ptr_nxt;
      end
      // Accept and drain together reload the register for 1 flit/clk.
      if (w_acc) begin
        r_out_vld  <= 1'b1;
        r_out_data <= w_acc_data;
        r_out_chn  <= r_ptr;
      end else if (w_drain) begin
        r_out_vld  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_umai_tx_chn_sched.sv
// Directed bench for umai_tx_chn_sched: queued flit sources, a drain/accept
// monitor and hand-computed channel/data/order expectations.
module tb_umai_tx_chn_sched;
  localparam int NCH = 6;

  logic                 i_clk = 1'b0;
  logic                 i_rst;
  logic                 i_en;
  logic [2:0]           c_first_chn_id;
  logic [2:0]           c_last_chn_id;
  logic                 i_mst_valid;
  logic                 o_mst_ready;
  logic [71:0]          i_mst_data;
  logic                 i_mst_last;
  logic                 i_slv_valid;
  logic                 o_slv_ready;
  logic [71:0]          i_slv_data;
  logic                 i_slv_last;
  logic [NCH-1:0]       o_tx_valid;
  logic [NCH-1:0]       i_tx_ready;
  logic [NCH-1:0][71:0] o_tx_data;
  logic                 o_busy;
  logic                 o_cfg_err;

  umai_tx_chn_sched #(.NumChannels(NCH)) u_dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_en           (i_en),
    .c_first_chn_id (c_first_chn_id),
    .c_last_chn_id  (c_last_chn_id),
    .i_mst_valid    (i_mst_valid),
    .o_mst_ready    (o_mst_ready),
    .i_mst_data     (i_mst_data),
    .i_mst_last     (i_mst_last),
    .i_slv_valid    (i_slv_valid),
    .o_slv_ready    (o_slv_ready),
    .i_slv_data     (i_slv_data),
    .i_slv_last     (i_slv_last),
    .o_tx_valid     (o_tx_valid),
    .i_tx_ready     (i_tx_ready),
    .o_tx_data      (o_tx_data),
    .o_busy         (o_busy),
    .o_cfg_err      (o_cfg_err)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [72:0] mst_q[$];
  logic [72:0] slv_q[$];
  int          d_chn[$];
  logic [71:0] d_dat[$];
  int          d_cyc[$];
  logic [71:0] a_dat[$];
  int          a_cyc[$];
  int          e_chn[$];
  logic [71:0] e_dat[$];
  logic        busy_h [0:8191];
  logic        m_acc = 1'b0;
  logic        s_acc = 1'b0;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] mk(input int src, input int pkt, input int idx);
    return {56'h0, src[3:0], pkt[3:0], idx[7:0]};
  endfunction

  task automatic push_pkt(input int src, input int pkt, input int n);
    for (int i = 0; i < n; i++) begin
      if (src == 0) mst_q.push_back({(i == n - 1), mk(src, pkt, i)});
      else          slv_q.push_back({(i == n - 1), mk(src, pkt, i)});
    end
  endtask

  task automatic clear_logs();
    d_chn.delete(); d_dat.delete(); d_cyc.delete();
    a_dat.delete(); a_cyc.delete();
  endtask

  task automatic exp_d(input int chn, input logic [71:0] dat);
    e_chn.push_back(chn);
    e_dat.push_back(dat);
  endtask

  task automatic check_drains(input string tag);
    check({tag, "_cnt"}, d_chn.size(), e_chn.size());
    for (int i = 0; i < e_chn.size(); i++) begin
      if (i < d_chn.size()) begin
        check($sformatf("%s_chn%0d", tag, i), d_chn[i], e_chn[i]);
        check($sformatf("%s_dat%0d", tag, i), d_dat[i], e_dat[i]);
      end
    end
    e_chn.delete();
    e_dat.delete();
  endtask

  task automatic wait_idle(input string tag, input int max);
    int  n  = 0;
    bit  ok = 0;
    while (!ok && n < max) begin
      @(negedge i_clk); #1;
      n++;
      ok = (mst_q.size() == 0) && (slv_q.size() == 0) && !i_mst_valid && !i_slv_valid && !o_busy;
    end
    if (!ok) check({tag, "_timeout"}, 0, 1);
    @(posedge i_clk); #1;
  endtask

  task automatic wait_acc(input string tag, input int cnt, input int max);
    int n = 0;
    while (a_dat.size() < cnt && n < max) begin
      @(negedge i_clk); #1;
      n++;
    end
    if (a_dat.size() < cnt) check({tag, "_acc_timeout"}, 0, 1);
  endtask

  initial forever begin
    @(posedge i_clk);
    cyc++;
  end

  initial forever begin
    @(negedge i_clk);
    busy_h[cyc] = o_busy;
    m_acc = i_mst_valid && o_mst_ready;
    s_acc = i_slv_valid && o_slv_ready;
    if (m_acc) begin a_dat.push_back(i_mst_data); a_cyc.push_back(cyc); end
    if (s_acc) begin a_dat.push_back(i_slv_data); a_cyc.push_back(cyc); end
    if (o_mst_ready && o_slv_ready) check("both_ready", 1, 0);
    for (int k = 0; k < NCH; k++) begin
      if (o_tx_valid[k] && i_tx_ready[k]) begin
        d_chn.push_back(k);
        d_dat.push_back(o_tx_data[k]);
        d_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    i_mst_valid = 0; i_mst_data = '0; i_mst_last = 0;
    i_slv_valid = 0; i_slv_data = '0; i_slv_last = 0;
    forever begin
      @(posedge i_clk); #1;
      if (m_acc && mst_q.size() > 0) mst_q.delete(0);
      if (s_acc && slv_q.size() > 0) slv_q.delete(0);
      if (mst_q.size() > 0) {i_mst_last, i_mst_data} = mst_q[0];
      else                  {i_mst_last, i_mst_data} = '0;
      i_mst_valid = (mst_q.size() > 0);
      if (slv_q.size() > 0) {i_slv_last, i_slv_data} = slv_q[0];
      else                  {i_slv_last, i_slv_data} = '0;
      i_slv_valid = (slv_q.size() > 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int last;
    i_rst = 1; i_en = 0; c_first_chn_id = 3'd0; c_last_chn_id = 3'd5; i_tx_ready = '1;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_tx_valid", o_tx_valid, 0);
    check("rst_mst_rdy", o_mst_ready, 0);
    check("rst_slv_rdy", o_slv_ready, 0);
    check("rst_busy", o_busy, 0);
    check("rst_tx_data", o_tx_data[0], 0);
    @(posedge i_clk); #1;
    i_rst = 0; i_en = 1;

    // 8-flit master packet over window 0..5
    clear_logs();
    push_pkt(0, 1, 8);
    wait_idle("t1", 60);
    for (int i = 0; i < 8; i++) exp_d(i % 6, mk(0, 1, i));
    check_drains("t1");
    if (d_cyc.size() == 8 && a_cyc.size() == 8) begin
      check("t1_latency", d_cyc[0], a_cyc[0] + 1);
      for (int i = 1; i < 8; i++) check($sformatf("t1_cyc%0d", i), d_cyc[i], d_cyc[0] + i);
      last = d_cyc[7];
      check("t1_busy_last", busy_h[last], 1);
      check("t1_busy_fall", busy_h[last + 1], 0);
    end

    // alternating grants from reset
    clear_logs();
    i_rst = 1;
    push_pkt(0, 0, 2); push_pkt(0, 1, 2);
    push_pkt(1, 0, 2); push_pkt(1, 1, 2);
    @(posedge i_clk); #1;
    i_rst = 0;
    wait_idle("t2", 80);
    check("t2_acc_cnt", a_dat.size(), 8);
    if (a_dat.size() == 8) begin
      check("t2_a0", a_dat[0], mk(0, 0, 0)); check("t2_a1", a_dat[1], mk(0, 0, 1));
      check("t2_a2", a_dat[2], mk(1, 0, 0)); check("t2_a3", a_dat[3], mk(1, 0, 1));
      check("t2_a4", a_dat[4], mk(0, 1, 0)); check("t2_a5", a_dat[5], mk(0, 1, 1));
      check("t2_a6", a_dat[6], mk(1, 1, 0)); check("t2_a7", a_dat[7], mk(1, 1, 1));
    end
    exp_d(0, mk(0, 0, 0)); exp_d(1, mk(0, 0, 1));
    exp_d(0, mk(1, 0, 0)); exp_d(1, mk(1, 0, 1));
    exp_d(0, mk(0, 1, 0)); exp_d(1, mk(0, 1, 1));
    exp_d(0, mk(1, 1, 0)); exp_d(1, mk(1, 1, 1));
    check_drains("t2");

    // channel 3 stalled for the second flit, window 2..4
    clear_logs();
    c_first_chn_id = 3'd2; c_last_chn_id = 3'd4;
    i_tx_ready = 6'b110111;
    push_pkt(0, 3, 4);
    begin
      int n = 0;
      while (!o_tx_valid[3] && n < 20) begin
        @(negedge i_clk); #1;
        n++;
      end
      if (!o_tx_valid[3]) check("t3_stall_timeout", 0, 1);
    end
    for (int j = 1; j <= 5; j++) begin
      if (j > 1) begin @(negedge i_clk); #1; end
      check($sformatf("t3_v3_%0d", j), o_tx_valid[3], 1);
      check($sformatf("t3_d3_%0d", j), o_tx_data[3], mk(0, 3, 1));
      check($sformatf("t3_v2_%0d", j), o_tx_valid[2], 0);
      check($sformatf("t3_v4_%0d", j), o_tx_valid[4], 0);
      check($sformatf("t3_rdy_%0d", j), o_mst_ready, (j == 5));
      if (j == 4) begin
        @(posedge i_clk); #1;
        i_tx_ready[3] = 1'b1;
      end
    end
    wait_idle("t3", 40);
    exp_d(2, mk(0, 3, 0)); exp_d(3, mk(0, 3, 1));
    exp_d(4, mk(0, 3, 2)); exp_d(2, mk(0, 3, 3));
    if (d_cyc.size() >= 2) check("t3_hold", d_cyc[1] - d_cyc[0], 5);
    check_drains("t3");

    // illegal windows, then single-channel window 1..1
    c_first_chn_id = 3'd0; c_last_chn_id = 3'd6; #1;
    check("t4_err_last6", o_cfg_err, 1);
    c_first_chn_id = 3'd3; c_last_chn_id = 3'd3; #1;
    check("t4_err_3_3", o_cfg_err, 0);
    c_first_chn_id = 3'd4; c_last_chn_id = 3'd1; #1;
    check("t4_err_4_1", o_cfg_err, 1);
    clear_logs();
    push_pkt(0, 4, 3);
    push_pkt(1, 4, 1);
    repeat (6) begin @(negedge i_clk); #1; end
    check("t4_no_acc", a_dat.size(), 0);
    check("t4_busy", o_busy, 0);
    check("t4_mst_rdy", o_mst_ready, 0);
    check("t4_slv_rdy", o_slv_ready, 0);
    @(posedge i_clk); #1;
    c_first_chn_id = 3'd1; c_last_chn_id = 3'd1; #1;
    check("t4_err_1_1", o_cfg_err, 0);
    wait_idle("t4", 40);
    exp_d(1, mk(1, 4, 0));
    exp_d(1, mk(0, 4, 0)); exp_d(1, mk(0, 4, 1)); exp_d(1, mk(0, 4, 2));
    check_drains("t4");

    // i_en dropped mid-packet, then held low with a pending packet
    clear_logs();
    c_first_chn_id = 3'd3; c_last_chn_id = 3'd5;
    push_pkt(0, 5, 4);
    wait_acc("t5", 1, 20);
    @(posedge i_clk); #1;
    i_en = 0;
    wait_idle("t5a", 40);
    check("t5_acc_cnt", a_dat.size(), 4);
    push_pkt(1, 5, 2);
    repeat (6) begin @(negedge i_clk); #1; end
    check("t5_en_low_acc", a_dat.size(), 4);
    check("t5_en_low_busy", o_busy, 0);
    check("t5_en_low_rdy", o_slv_ready, 0);
    @(posedge i_clk); #1;
    i_en = 1;
    wait_idle("t5b", 40);
    exp_d(3, mk(0, 5, 0)); exp_d(4, mk(0, 5, 1)); exp_d(5, mk(0, 5, 2)); exp_d(3, mk(0, 5, 3));
    exp_d(3, mk(1, 5, 0)); exp_d(4, mk(1, 5, 1));
    check_drains("t5");

    // asynchronous reset mid-packet
    clear_logs();
    c_first_chn_id = 3'd2; c_last_chn_id = 3'd4;
    push_pkt(0, 6, 6);
    wait_acc("t6", 2, 20);
    @(posedge i_clk); #3;
    check("t6_pre_valid", (o_tx_valid != 0), 1);
    check("t6_pre_rdy", o_mst_ready, 1);
    i_rst = 1; #1;
    check("t6_rst_valid", o_tx_valid, 0);
    check("t6_rst_mst_rdy", o_mst_ready, 0);
    check("t6_rst_slv_rdy", o_slv_ready, 0);
    check("t6_rst_busy", o_busy, 0);
    @(posedge i_clk); #2;
    mst_q.delete();
    slv_q.delete();
    clear_logs();
    push_pkt(0, 7, 1);
    push_pkt(1, 7, 1);
    @(posedge i_clk); #1;
    i_rst = 0;
    wait_idle("t6", 40);
    check("t6_acc_cnt", a_dat.size(), 2);
    if (a_dat.size() == 2) check("t6_first_mst", a_dat[0], mk(0, 7, 0));
    exp_d(2, mk(0, 7, 0)); exp_d(2, mk(1, 7, 0));
    check_drains("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
